// File: rtl/oclib_xxtea_encrypt.sv
// Iterative XXTEA encryptor for one 64-bit block (2 words), valid/ready on both sides.
// Define OC_XXTEA_ENCRYPT_DUAL_MIX_EN to evaluate both half-round mixes per cycle.
module oclib_xxtea_encrypt #(
  parameter int          Rounds = 32,
  parameter logic [31:0] Delta  = 32'h9E3779B9
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             inValid,
  output logic             inReady,
  input  logic [1:0][31:0] in,
  input  logic [127:0]     key,
  output logic             outValid,
  input  logic             outReady,
  output logic [1:0][31:0] out,
  output logic             busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  localparam logic [5:0] LastRound = 6'(Rounds - 1);

  state_e           state_q, state_d;
  logic [1:0][31:0] v_q, v_d;
  logic [31:0]      sum_q, sum_d;
  logic [127:0]     key_q, key_d;
  logic [5:0]       round_q, round_d;
  logic             phase_q, phase_d;
  logic             live_q;
  logic [31:0]      v0_new, v1_new;

  function automatic logic [31:0] mx(input logic [31:0] y, input logic [31:0] z,
                                     input logic [31:0] s, input logic p,
                                     input logic [127:0] k);
    logic [1:0] idx;
    idx = {1'b0, p} ^ s[3:2];
    return (((z >> 5) ^ (y << 2)) + ((y >> 3) ^ (z << 4))) ^
           ((s ^ y) + (k[32*idx +: 32] ^ z));
  endfunction

  // Phase 0 mixes v[1] into v[0]; phase 1 mixes the freshly updated v[0] into v[1].
  assign v0_new = v_q[0] + mx(v_q[1], v_q[1], sum_q, 1'b0, key_q);
`ifdef OC_XXTEA_ENCRYPT_DUAL_MIX_EN
  assign v1_new = v_q[1] + mx(v0_new, v0_new, sum_q, 1'b1, key_q);
`else
  assign v1_new = v_q[1] + mx(v_q[0], v_q[0], sum_q, 1'b1, key_q);
`endif

  always_comb begin
    // NOTE: every next-state signal gets a default here so no path infers a latch.
    state_d = state_q;
    v_d     = v_q;
    sum_d   = sum_q;
    key_d   = key_q;
    round_d = round_q;
    phase_d = phase_q;
    unique case (state_q)
      IDLE: begin
        if (inValid && live_q) begin
          v_d     = in;
          key_d   = key;
          sum_d   = Delta;
          round_d = '0;
          phase_d = 1'b0;
          state_d = RUN;
        end
      end
      RUN: begin
`ifdef OC_XXTEA_ENCRYPT_DUAL_MIX_EN
        v_d = {v1_new, v0_new};
        if (round_q == LastRound) begin
          state_d = DONE;
        end else begin
          sum_d   = sum_q + Delta;
          round_d = round_q + 6'd1;
        end
`else
        if (!phase_q) begin
          v_d[0]  = v0_new;
          phase_d = 1'b1;
        end else begin
          v_d[1]  = v1_new;
          phase_d = 1'b0;
          if (round_q == LastRound) begin
            state_d = DONE;
          end else begin
            sum_d   = sum_q + Delta;
            round_d = round_q + 6'd1;
          end
        end
`endif
      end
      DONE: begin
        if (outReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      v_q     <= '0;
      sum_q   <= '0;
      key_q   <= '0;
      round_q <= '0;
      phase_q <= 1'b0;
      live_q  <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register updating from pre-edge values.
      state_q <= state_d;
      v_q     <= v_d;
      sum_q   <= sum_d;
      key_q   <= key_d;
      round_q <= round_d;
      phase_q <= phase_d;
      live_q  <= 1'b1;
    end
  end

  // live_q holds inReady low until the first edge after reset releases.
  assign inReady  = (state_q == IDLE) && live_q;
  assign outValid = (state_q == DONE);
  assign busy     = (state_q != IDLE);
  assign out      = v_q;

endmodule

// File: tb/tb_oclib_xxtea_encrypt.sv
// Scoreboard bench for oclib_xxtea_encrypt: reference XXTEA encrypt/decrypt models,
// latency, stall, reset-abort, back-to-back and random stress scenarios.
`timescale 1ns/1ps
module tb_oclib_xxtea_encrypt;

  localparam int          R     = 32;
  localparam logic [31:0] DELTA = 32'h9E3779B9;
`ifdef OC_XXTEA_ENCRYPT_DUAL_MIX_EN
  localparam int LAT = R;
`else
  localparam int LAT = 2 * R;
`endif
  localparam int PERIOD = LAT + 2;
  localparam int N_RAND = 1000;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             inValid = 1'b0;
  logic             outReady = 1'b0;
  logic [1:0][31:0] tb_in = '0;
  logic [127:0]     key_w = '0;
  logic             inReady, outValid, busy;
  logic [1:0][31:0] out_w;

  int          errors = 0;
  int          checks = 0;
  logic [63:0] sb[$];
  int          acc_edges[$];
  int          cyc = 0;
  int          accept_edge = 0;
  int          latency = -1;
  int          n_out = 0;
  logic        prev_ov = 1'b0;
  logic [63:0] last_out = '0;

  oclib_xxtea_encrypt dut (
    .clock    (clock),
    .reset    (reset),
    .inValid  (inValid),
    .inReady  (inReady),
    .in       (tb_in),
    .key      (key_w),
    .outValid (outValid),
    .outReady (outReady),
    .out      (out_w),
    .busy     (busy)
  );

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, errors=%0d", errors);
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  function automatic logic [31:0] kw(input logic [127:0] k, input int i);
    return k[32*i +: 32];
  endfunction

  function automatic logic [31:0] tmx(input logic [31:0] y, input logic [31:0] z,
                                      input logic [31:0] sum, input int p, input int e,
                                      input logic [127:0] k);
    return (((z >> 5) ^ (y << 2)) + ((y >> 3) ^ (z << 4))) ^
           ((sum ^ y) + (kw(k, (p & 3) ^ e) ^ z));
  endfunction

  function automatic logic [63:0] ref_enc(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] v0, v1, y, z, sum;
    int e;
    v0 = blk[31:0]; v1 = blk[63:32]; sum = '0; z = v1;
    for (int r = 0; r < R; r++) begin
      sum = sum + DELTA;
      e   = int'((sum >> 2) & 32'd3);
      y = v1; v0 = v0 + tmx(y, z, sum, 0, e, k); z = v0;
      y = v0; v1 = v1 + tmx(y, z, sum, 1, e, k); z = v1;
    end
    return {v1, v0};
  endfunction

  function automatic logic [63:0] ref_dec(input logic [63:0] blk, input logic [127:0] k);
    logic [31:0] v0, v1, y, z, sum;
    int e;
    v0 = blk[31:0]; v1 = blk[63:32]; sum = DELTA * R; y = v0;
    for (int r = 0; r < R; r++) begin
      e = int'((sum >> 2) & 32'd3);
      z = v0; v1 = v1 - tmx(y, z, sum, 1, e, k); y = v1;
      z = v1; v0 = v0 - tmx(y, z, sum, 0, e, k); y = v0;
      sum = sum - DELTA;
    end
    return {v1, v0};
  endfunction

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clock) begin
    logic [63:0] exp_v;
    if (reset) begin
      prev_ov = 1'b0;
    end else begin
      if (outValid && !prev_ov) latency = cyc - accept_edge;
      prev_ov = outValid;
      if (inValid && inReady) begin
        sb.push_back(ref_enc(tb_in, key_w));
        accept_edge = cyc + 1;
        acc_edges.push_back(cyc + 1);
      end
      if (outValid && outReady) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL sb_underflow: out=%h with no expected block", out_w);
        end else begin
          exp_v = sb.pop_front();
          if (out_w !== exp_v) begin
            errors++;
            $display("FAIL sb_compare: out=%h expected=%h", out_w, exp_v);
          end
        end
        last_out = out_w;
        n_out++;
      end
    end
  end

  // ---------------- drivers ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic send(input logic [63:0] v, input logic [127:0] k);
    bit ok;
    tb_in = v; key_w = k; inValid = 1'b1; ok = 0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge clock);
      if (inReady) ok = 1;
      step();
    end
    inValid = 1'b0;
    checks++;
    if (!ok) begin errors++; $display("FAIL accept_timeout: inReady=%b expected 1", inReady); end
  endtask

  task automatic wait_out(input string name);
    bit ok;
    ok = 0;
    for (int i = 0; i < LAT + 200 && !ok; i++) begin
      @(negedge clock);
      if (outValid) ok = 1;
    end
    checks++;
    if (!ok) begin errors++; $display("FAIL %s_out_timeout: outValid=%b expected 1", name, outValid); end
  endtask

  task automatic collect(input string name);
    wait_out(name);
    @(posedge clock); #1;
    outReady = 1'b1;
    step();
    outReady = 1'b0;
    checks++;
    if (inReady !== 1'b1 || outValid !== 1'b0) begin
      errors++;
      $display("FAIL %s_idle_after_hs: inReady=%b outValid=%b expected 1 0", name, inReady, outValid);
    end
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(posedge clock);
    #1;
    checks++;
    if ({inReady, outValid, busy} !== 3'b000 || out_w !== 64'd0) begin
      errors++;
      $display("FAIL reset_values: rdy/ov/busy=%b out=%h expected 000 0", {inReady, outValid, busy}, out_w);
    end
    reset = 1'b0;
    #1;
    checks++;
    if (inReady !== 1'b0) begin errors++; $display("FAIL ready_before_edge: inReady=%b expected 0", inReady); end
    step();
    checks++;
    if (inReady !== 1'b1) begin errors++; $display("FAIL ready_after_edge: inReady=%b expected 1", inReady); end
  endtask

  task automatic test_known();
    logic [63:0]  pt;
    logic [127:0] k;
    pt = 64'h89abcdef_12345678;
    k  = 128'h44444444_33333333_22222222_11111111;
    latency = -1;
    send(pt, k);
    collect("known");
    checks++;
    if (latency !== LAT) begin errors++; $display("FAIL known_latency: got %0d expected %0d", latency, LAT); end
    checks++;
    if (ref_dec(last_out, k) !== pt) begin
      errors++;
      $display("FAIL known_roundtrip: decrypted=%h expected=%h", ref_dec(last_out, k), pt);
    end
  endtask

  task automatic test_zero();
    send(64'd0, 128'd0);
    wait_out("zero");
    checks++;
    if (dut.sum_q !== 32'hC6EF3720) begin
      errors++;
      $display("FAIL zero_final_sum: got %h expected c6ef3720", dut.sum_q);
    end
    collect("zero");
  endtask

  task automatic test_stall();
    logic [63:0] held;
    int bad;
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    wait_out("stall");
    held = out_w;
    bad  = 0;
    for (int i = 0; i < 100; i++) begin
      step();
      tb_in   = {$urandom, $urandom};
      key_w   = {$urandom, $urandom, $urandom, $urandom};
      inValid = 1'($urandom_range(0, 1));
      @(negedge clock);
      if (out_w !== held || outValid !== 1'b1 || inReady !== 1'b0) bad++;
    end
    @(posedge clock); #1;
    inValid = 1'b0;
    checks++;
    if (bad != 0) begin errors++; $display("FAIL stall_hold: %0d bad cycles expected 0", bad); end
    collect("stall");
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL stall_extra_accept: pending=%0d expected 0", sb.size()); end
  endtask

  task automatic test_reset_abort();
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    repeat (30) step();
    reset = 1'b1;
    #1;
    checks++;
    if ({outValid, busy, inReady} !== 3'b000) begin
      errors++;
      $display("FAIL abort_run: ov/busy/rdy=%b expected 000", {outValid, busy, inReady});
    end
    sb.delete();
    step(); reset = 1'b0; step();
    send({$urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom});
    wait_out("abort_done");
    @(posedge clock); #1;
    reset = 1'b1;
    #1;
    checks++;
    if ({outValid, busy} !== 2'b00) begin
      errors++;
      $display("FAIL abort_done: ov/busy=%b expected 00", {outValid, busy});
    end
    sb.delete();
    step(); reset = 1'b0; step();
    send(64'hfeedface_0badf00d, 128'h0f1e2d3c_4b5a6978_8796a5b4_c3d2e1f0);
    collect("after_abort");
  endtask

  task automatic test_back_to_back();
    bit ok;
    int base;
    base = n_out;
    acc_edges.delete();
    outReady = 1'b1;
    for (int j = 0; j < 4; j++) begin
      tb_in = {$urandom, $urandom};
      key_w = {$urandom, $urandom, $urandom, $urandom};
      inValid = 1'b1; ok = 0;
      for (int i = 0; i < 400 && !ok; i++) begin
        @(negedge clock);
        if (inReady) ok = 1;
        step();
      end
    end
    inValid = 1'b0;
    for (int i = 0; i < 400 && n_out < base + 4; i++) step();
    outReady = 1'b0;
    checks++;
    if (n_out != base + 4 || acc_edges.size() != 4) begin
      errors++;
      $display("FAIL b2b_count: outputs=%0d accepts=%0d expected 4 4", n_out - base, acc_edges.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++;
        if (acc_edges[i+1] - acc_edges[i] != PERIOD) begin
          errors++;
          $display("FAIL b2b_period: got %0d expected %0d", acc_edges[i+1] - acc_edges[i], PERIOD);
        end
      end
    end
  endtask

  task automatic test_random();
    int base;
    bit prod_ok;
    base = n_out;
    prod_ok = 1;
    fork
      begin
        bit ok;
        for (int j = 0; j < N_RAND && prod_ok; j++) begin
          inValid = 1'b0;
          repeat ($urandom_range(0, 1)) step();
          tb_in = {$urandom, $urandom};
          key_w = {$urandom, $urandom, $urandom, $urandom};
          inValid = 1'b1; ok = 0;
          for (int i = 0; i < 400 && !ok; i++) begin
            @(negedge clock);
            if (inReady) ok = 1;
            step();
          end
          if (!ok) prod_ok = 0;
        end
        inValid = 1'b0;
      end
      begin
        for (int i = 0; i < N_RAND * 80 && n_out < base + N_RAND && prod_ok; i++) begin
          outReady = ($urandom_range(0, 7) != 0);
          step();
        end
        outReady = 1'b0;
      end
    join
    checks++;
    if (!prod_ok) begin errors++; $display("FAIL rand_accept_timeout: producer stalled, expected progress"); end
    checks++;
    if (n_out != base + N_RAND) begin
      errors++;
      $display("FAIL rand_count: outputs=%0d expected %0d", n_out - base, N_RAND);
    end
    checks++;
    if (sb.size() != 0) begin errors++; $display("FAIL rand_leftover: pending=%0d expected 0", sb.size()); end
  endtask

  initial begin
    test_reset();
    test_known();
    test_zero();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
